match_collector_l9: RTL and testbench
=====================================

# match_collector_l9

Downstream stage of the length-9 Cuckoo lookup engine. Consumes the per-cycle hit flags (`compare_out*`) and suffix codes (`suffix*`) from the case-sensitive and nocase lanes, realigns them with the payload byte offset that produced them, and queues one match record per hit cycle into a small FIFO drained over a valid/ready port. Also tracks packet boundaries and emits a per-packet match count once all in-flight lookups have retired.

## Interface
Parameters:
- `DEPTH`, 16: record FIFO depth, power of two.
- `OFFSET_W`, 16: byte-offset width.
- `PIPE_LAT`, 4: cycles from an `enable` byte to its `compare_out`/`suffix` result.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `enable` in 1: one payload byte accepted by the lookup stage this cycle.
- `sop` in 1: qualified by `enable`; this byte is offset 0 of a new packet.
- `eop` in 1: qualified by `enable`; last byte of the packet.
- `compare_out` in 2: case-lane hits, [0] port A, [1] port B.
- `suffix` in 2: case-lane suffix code.
- `compare_out_nocase` in 2: nocase-lane hits.
- `suffix_nocase` in 2: nocase-lane suffix code.
- `m_valid` out 1: record available.
- `m_ready` in 1: consumer accepts record.
- `m_data` out OFFSET_W+8: {offset, hit_mask[3:0], suffix_nocase[1:0], suffix[1:0]}; hit_mask = {compare_out_nocase, compare_out}.
- `pkt_done` out 1: one-cycle pulse, packet fully retired.
- `pkt_matches` out 16: records pushed for the retired packet; valid with `pkt_done`, held until the next `pkt_done`.
- `overflow` out 1: sticky; a record was dropped.
- `drop_cnt` out 16: dropped records, saturating at 0xFFFF.

## Operation
- Byte counter: on `enable`, the current offset is `sop ? 0 : cnt`, and `cnt` is set to current offset + 1. Wraps modulo 2^OFFSET_W.
- Alignment shift register, PIPE_LAT deep, carries {enable, offset, eop}. Its tail, `v_d`/`off_d`/`eop_d`, coincides with the lookup results for that byte.
- Hit cycle: `v_d`=1 and hit_mask≠0.
  - FIFO not full, or full with a simultaneous pop: push the record and increment `pkt_cnt`.
  - FIFO full and no pop: drop the record, set `overflow`, increment `drop_cnt`.
- Hit flags when `v_d`=0 are ignored.
- Packet FSM:
  - IDLE: on `enable`&&`sop`, go to ACTIVE and clear `pkt_cnt`.
  - ACTIVE: stay until `eop_d`=1.
  - `eop_d`=1 (in any state): hit processing for that byte completes first; at the next edge latch `pkt_matches` = final `pkt_cnt`, pulse `pkt_done`, go to IDLE.
  - `sop` while ACTIVE (no prior eop): `pkt_cnt` is cleared and the state stays ACTIVE. In-flight results keep their own offsets and count into the new packet.
- FIFO: DEPTH entries with registered output. `m_data` is stable while `m_valid`&&!`m_ready`.

## Timing
- Reset: `m_valid`=0, `m_data`=0, `pkt_done`=0, `pkt_matches`=0, `overflow`=0, `drop_cnt`=0. Counter, shift register and FIFO are cleared; FSM goes to IDLE.
- A push at edge N makes `m_valid`=1 after edge N (one-cycle latency). Pop occurs on `m_valid`&&`m_ready`.
- `pkt_done` asserts PIPE_LAT+1 cycles after the `enable`&&`eop` cycle.
- Reset mid-packet: everything in flight is discarded and no `pkt_done` is issued.
- `enable` gaps: offsets stay contiguous and the shift register still advances every cycle.

## Configuration
- `MATCH_COLLECTOR_NOCASE_EN` defined: nocase lane active as described.
- Not defined:
  - nocase inputs are ignored;
  - hit_mask[3:2]=0 and `m_data` suffix_nocase field = 0;
  - hit cycle = `v_d` && `compare_out`≠0.

## Test plan
- Reset, then a 12-byte packet (`sop` at byte 0, `eop` at byte 11); `compare_out`=2'b01, `suffix`=2'b10 aligned to byte 5 → one record {offset 5, mask 0001, suffix 10}; `pkt_done` with `pkt_matches`=1 at PIPE_LAT+1 cycles after byte 11.
- Same cycle, `compare_out`=2'b11 and `compare_out_nocase`=2'b10 at byte 3 → a single record with mask 1011 (0011 with the macro undefined).
- `m_ready`=0, 18 hit bytes → 16 records held, `overflow`=1, `drop_cnt`=2; then `m_ready`=1 → records drain in offset order.
- FIFO full, hit coincident with a pop → record accepted, `drop_cnt` unchanged.
- `sop` at byte 7 of an unterminated packet, then bytes 0–3 with `eop` → offsets restart at 0 and `pkt_matches` counts only hits retired after the new `sop`.
- `enable` toggling 1/0 across 8 bytes with hits on every byte → offsets 0..7 contiguous; `rst` asserted mid-stream → `m_valid`=0 next cycle and no `pkt_done`.

Source files
------------

// File: rtl/match_collector_l9.sv
// Realigns length-9 Cuckoo lookup hits with their byte offsets, queues match records
// and reports per-packet match counts. Optional nocase lane: MATCH_COLLECTOR_NOCASE_EN.
module match_collector_l9 #(
  parameter int DEPTH    = 16,
  parameter int OFFSET_W = 16,
  parameter int PIPE_LAT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  sop,
  input  logic                  eop,
  input  logic [1:0]            compare_out,
  input  logic [1:0]            suffix,
  input  logic [1:0]            compare_out_nocase,
  input  logic [1:0]            suffix_nocase,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [OFFSET_W+7:0]   m_data,
  output logic                  pkt_done,
  output logic [15:0]           pkt_matches,
  output logic                  overflow,
  output logic [15:0]           drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = OFFSET_W + 8;

  typedef enum logic {IDLE, ACTIVE} state_t;

  // ---------------- byte offset counter ----------------
  logic [OFFSET_W-1:0] cnt;
  logic [OFFSET_W-1:0] cur_off;

  assign cur_off = sop ? '0 : cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (enable)
      cnt <= cur_off + OFFSET_W'(1);
  end

  // ---------------- alignment shift register ----------------
  logic                sr_v   [PIPE_LAT];
  logic [OFFSET_W-1:0] sr_off [PIPE_LAT];
  logic                sr_eop [PIPE_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        sr_v[i]   <= 1'b0;
        sr_off[i] <= '0;
        sr_eop[i] <= 1'b0;
      end
    end else begin
      sr_v[0]   <= enable;
      sr_off[0] <= cur_off;
      sr_eop[0] <= enable & eop;
      for (int i = 1; i < PIPE_LAT; i++) begin
        sr_v[i]   <= sr_v[i-1];
        sr_off[i] <= sr_off[i-1];
        sr_eop[i] <= sr_eop[i-1];
      end
    end
  end

  logic                v_d;
  logic [OFFSET_W-1:0] off_d;
  logic                eop_d;

  assign v_d   = sr_v[PIPE_LAT-1];
  assign off_d = sr_off[PIPE_LAT-1];
  assign eop_d = sr_eop[PIPE_LAT-1];

  // ---------------- hit qualification ----------------
  logic [3:0] hit_mask;
  logic [1:0] sfx_nc;

`ifdef MATCH_COLLECTOR_NOCASE_EN
  assign hit_mask = {compare_out_nocase, compare_out};
  assign sfx_nc   = suffix_nocase;
`else
  logic nocase_unused;
  assign nocase_unused = ^{compare_out_nocase, suffix_nocase};
  assign hit_mask      = {2'b00, compare_out};
  assign sfx_nc        = 2'b00;
`endif

  logic          hit;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic [DW-1:0] rec;
  logic [AW:0]   count;

  assign hit  = v_d && (hit_mask != 4'b0000);
  assign full = (count == (AW+1)'(DEPTH));
  assign pop  = m_valid && m_ready;
  // A full FIFO still takes the record when the head leaves on the same edge.
  assign push = hit && (!full || pop);
  assign drop = hit && full && !pop;
  assign rec  = {off_d, hit_mask, sfx_nc, suffix};

  // ---------------- record FIFO ----------------
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // NOTE: storage is deliberately not reset; m_data is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= rec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign m_valid = (count != '0);
  assign m_data  = m_valid ? mem[rd_ptr] : '0;

  // ---------------- overflow accounting ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // ---------------- packet FSM ----------------
  state_t state;
  state_t state_next;
  logic   cnt_clear;
  logic   retire;

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    if (enable && sop)
      state_next = ACTIVE;
    else if (eop_d)
      state_next = IDLE;
  end

  always_comb begin
    cnt_clear = enable && sop;
    retire    = eop_d;
  end

  logic [15:0] pkt_cnt;
  logic [15:0] pkt_cnt_sum;

  // The retiring byte's own hit is part of the final count.
  assign pkt_cnt_sum = pkt_cnt + 16'(push);

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt     <= '0;
      pkt_matches <= '0;
      pkt_done    <= 1'b0;
    end else begin
      pkt_done <= retire;
      if (retire)
        pkt_matches <= pkt_cnt_sum;
      pkt_cnt <= cnt_clear ? 16'(push) : pkt_cnt_sum;
    end
  end

endmodule

// File: tb/tb_match_collector_l9.sv
// Directed bench for match_collector_l9: a bench-side lookup pipeline feeds hits with
// the right latency, and a queue scoreboard predicts records, drops and packet counts.
module tb_match_collector_l9;

  localparam int DEPTH = 16;
  localparam int OW    = 16;
  localparam int L     = 4;

`ifdef MATCH_COLLECTOR_NOCASE_EN
  localparam bit NC = 1'b1;
`else
  localparam bit NC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          sop = 1'b0;
  logic          eop = 1'b0;
  logic [1:0]    compare_out = '0;
  logic [1:0]    suffix = '0;
  logic [1:0]    compare_out_nocase = '0;
  logic [1:0]    suffix_nocase = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [OW+7:0] m_data;
  logic          pkt_done;
  logic [15:0]   pkt_matches;
  logic          overflow;
  logic [15:0]   drop_cnt;

  match_collector_l9 #(.DEPTH(DEPTH), .OFFSET_W(OW), .PIPE_LAT(L)) dut (
    .clk                (clk),
    .rst                (rst),
    .enable             (enable),
    .sop                (sop),
    .eop                (eop),
    .compare_out        (compare_out),
    .suffix             (suffix),
    .compare_out_nocase (compare_out_nocase),
    .suffix_nocase      (suffix_nocase),
    .m_valid            (m_valid),
    .m_ready            (m_ready),
    .m_data             (m_data),
    .pkt_done           (pkt_done),
    .pkt_matches        (pkt_matches),
    .overflow           (overflow),
    .drop_cnt           (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Scoreboard and lookup-latency model
  logic [OW+7:0] q[$];
  logic          p_v   [L];
  logic [OW-1:0] p_off [L];
  logic          p_eop [L];
  logic [1:0]    p_c   [L];
  logic [1:0]    p_sf  [L];
  logic [1:0]    p_cn  [L];
  logic [1:0]    p_sfn [L];
  logic [OW-1:0] cnt_m       = '0;
  logic [15:0]   pkt_cnt_m   = '0;
  logic [15:0]   exp_matches = '0;
  logic [15:0]   exp_drops   = '0;
  logic          exp_done    = 1'b0;
  logic          exp_ovf     = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    q.delete();
    for (int k = 0; k < L; k++) begin
      p_v[k] = 1'b0; p_off[k] = '0; p_eop[k] = 1'b0;
      p_c[k] = '0; p_sf[k] = '0; p_cn[k] = '0; p_sfn[k] = '0;
    end
    cnt_m = '0; pkt_cnt_m = '0; exp_matches = '0; exp_drops = '0;
    exp_done = 1'b0; exp_ovf = 1'b0;
  endtask

  // One clock cycle: drive inputs, check outputs of the previous edge, advance the model.
  task automatic cycle(input logic en, input logic s, input logic e,
                       input logic [1:0] c, input logic [1:0] sf,
                       input logic [1:0] cn, input logic [1:0] sfn,
                       input logic rdy, input logic rs);
    logic          pop;
    logic          push;
    logic [3:0]    msk;
    logic [15:0]   sum;
    logic [OW-1:0] off;
    logic [OW+7:0] rec;
    enable = en; sop = s; eop = e; m_ready = rdy; rst = rs;
    compare_out = p_c[L-1]; suffix = p_sf[L-1];
    compare_out_nocase = p_cn[L-1]; suffix_nocase = p_sfn[L-1];
    @(negedge clk);
    check("m_valid", 32'(m_valid), 32'(q.size() != 0));
    check("pkt_done", 32'(pkt_done), 32'(exp_done));
    check("pkt_matches", 32'(pkt_matches), 32'(exp_matches));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("drop_cnt", 32'(drop_cnt), 32'(exp_drops));
    pop = (q.size() != 0) && rdy;
    if (pop) begin
      rec = q.pop_front();
      check("m_data", 32'(m_data), 32'(rec));
    end
    if (rs) begin
      clear_model();
    end else begin
      push = 1'b0;
      msk  = {(NC ? p_cn[L-1] : 2'b00), p_c[L-1]};
      if (p_v[L-1] && msk != 4'b0000) begin
        if (q.size() < DEPTH || pop) begin
          q.push_back({p_off[L-1], msk, (NC ? p_sfn[L-1] : 2'b00), p_sf[L-1]});
          push = 1'b1;
        end else begin
          exp_ovf = 1'b1;
          if (exp_drops != 16'hFFFF) exp_drops = exp_drops + 16'd1;
        end
      end
      sum      = pkt_cnt_m + 16'(push);
      exp_done = p_v[L-1] && p_eop[L-1];
      if (exp_done) exp_matches = sum;
      pkt_cnt_m = (en && s) ? 16'(push) : sum;
      off = s ? '0 : cnt_m;
      if (en) cnt_m = off + OW'(1);
      for (int k = L - 1; k > 0; k--) begin
        p_v[k] = p_v[k-1]; p_off[k] = p_off[k-1]; p_eop[k] = p_eop[k-1];
        p_c[k] = p_c[k-1]; p_sf[k] = p_sf[k-1]; p_cn[k] = p_cn[k-1]; p_sfn[k] = p_sfn[k-1];
      end
      p_v[0] = en; p_off[0] = off; p_eop[0] = en && e;
      p_c[0] = c; p_sf[0] = sf; p_cn[0] = cn; p_sfn[0] = sfn;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic byte_in(input logic s, input logic e, input logic [1:0] c, input logic [1:0] sf,
                         input logic [1:0] cn, input logic [1:0] sfn, input logic rdy);
    cycle(1'b1, s, e, c, sf, cn, sfn, rdy, 1'b0);
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, rdy, 1'b0);
  endtask

  initial begin
    clear_model();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 12-byte packet, single case-lane hit on byte 5
    for (int i = 0; i < 12; i++)
      byte_in(i == 0, i == 11, (i == 5) ? 2'b01 : 2'b00, (i == 5) ? 2'b10 : 2'b00,
              2'b00, 2'b00, 1'b1);
    idle(8, 1'b1);

    // Both lanes hit on byte 3; junk hits on gap cycles must be ignored
    for (int i = 0; i < 6; i++)
      byte_in(i == 0, i == 5, (i == 3) ? 2'b11 : 2'b00, (i == 3) ? 2'b01 : 2'b00,
              (i == 3) ? 2'b10 : 2'b00, (i == 3) ? 2'b11 : 2'b00, 1'b1);
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 2'b11, 2'b11, 2'b11, 2'b11, 1'b1, 1'b0);
    idle(8, 1'b1);

    // Overflow: 18 hits with the consumer stalled, then drain
    for (int i = 0; i < 18; i++)
      byte_in(i == 0, i == 17, 2'b01, 2'(i), 2'b00, 2'b00, 1'b0);
    idle(6, 1'b0);
    idle(20, 1'b1);

    // Full FIFO, the 17th hit retires in the same cycle as a pop
    for (int i = 0; i < 17; i++)
      byte_in(i == 0, i == 16, 2'b01, 2'(i), 2'b00, 2'b00, 1'b0);
    idle(3, 1'b0);
    idle(20, 1'b1);

    // sop inside an unterminated packet
    for (int i = 0; i < 7; i++)
      byte_in(i == 0, 1'b0, (i == 2 || i == 5) ? 2'b01 : 2'b00, 2'b01, 2'b00, 2'b00, 1'b1);
    for (int i = 0; i < 4; i++)
      byte_in(i == 0, i == 3, (i == 1) ? 2'b01 : 2'b00, 2'b11, 2'b00, 2'b00, 1'b1);
    idle(8, 1'b1);

    // enable toggling with hits every byte, then reset while results are in flight
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0)
        byte_in(i == 0, i == 14, 2'b10, 2'(i / 2), 2'b00, 2'b00, 1'b0);
      else
        cycle(1'b0, 1'b0, 1'b0, 2'b01, 2'b11, 2'b01, 2'b11, 1'b0, 1'b0);
    end
    cycle(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    idle(10, 1'b1);

    check("queue_empty_at_end", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
